// File: rtl/seg7_dual_mux.sv
// Dual common-anode seven-segment multiplexer.
// Frame-latched digits, blanking between slots, registered outputs.
module seg7_dual_mux #(
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    // Counter must also hold BLANK_CYCLES-1 should blanking ever exceed a slot.
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        SHOW0,
        BLANK0,
        SHOW1,
        BLANK1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    sh0, sh1, sh0_nx, sh1_nx;
    logic [6:0]    seg_nx;
    logic [1:0]    an_nx;
    logic          tick_nx;
    logic          enter0;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b1111111;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot sequencing, frame capture and next registered outputs.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        enter0   = 1'b0;
        unique case (state)
            SHOW0: begin
                if (cnt == SHOW_LAST) begin
                    state_nx = BLANK0;
                    cnt_nx   = '0;
                end
            end
            BLANK0: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = SHOW1;
                    cnt_nx   = '0;
                end
            end
            SHOW1: begin
                if (cnt == SHOW_LAST) begin
                    state_nx = BLANK1;
                    cnt_nx   = '0;
                end
            end
            BLANK1: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = SHOW0;
                    cnt_nx   = '0;
                    enter0   = 1'b1;
                end
            end
        endcase

        sh0_nx  = enter0 ? digit0 : sh0;
        sh1_nx  = enter0 ? digit1 : sh1;
        tick_nx = enter0;

        seg_nx = 7'b1111111;
        an_nx  = 2'b11;
        unique case (state_nx)
            SHOW0: begin
                an_nx  = 2'b10;
                seg_nx = decode(sh0_nx);
            end
            SHOW1: begin
                an_nx  = 2'b01;
                seg_nx = decode(sh1_nx);
            end
            default: begin
                an_nx  = 2'b11;
                seg_nx = 7'b1111111;
            end
        endcase
    end

    // State, shadow digits and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= BLANK1;
            cnt        <= '0;
            sh0        <= 4'h0;
            sh1        <= 4'h0;
            seg        <= 7'b1111111;
            an         <= 2'b11;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sh0        <= sh0_nx;
            sh1        <= sh1_nx;
            seg        <= seg_nx;
            an         <= an_nx;
            frame_tick <= tick_nx;
        end
    end

endmodule

// File: tb/tb_seg7_dual_mux.sv
// Directed bench for seg7_dual_mux with a per-cycle expected-output queue.
// Small instance checked cycle by cycle; default instance checked for timing.
module tb_seg7_dual_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_def;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [6:0] seg, seg_d;
    logic [1:0] an, an_d;
    logic       frame_tick, tick_d;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    int         pos;
    logic [3:0] m0, m1;

    always #5 clk = ~clk;

    seg7_dual_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    seg7_dual_mux u_def (
        .clk(clk), .reset(rst_def), .digit0(digit0), .digit1(digit1),
        .seg(seg_d), .an(an_d), .frame_tick(tick_d)
    );

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, queue the expected {an,seg,tick}, compare after the edge.
    task automatic step(input logic r, input logic [3:0] d0, input logic [3:0] d1);
        logic [9:0] e;
        logic [9:0] got;
        reset  = r;
        digit0 = d0;
        digit1 = d1;
        if (!r) begin
            pos = 0;
            m0  = 4'h0;
            m1  = 4'h0;
        end else begin
            pos = (pos + 1) % 12;
            if (pos == 2) begin
                m0 = d0;
                m1 = d1;
            end
        end
        if (!r)
            e = {2'b11, 7'b1111111, 1'b0};
        else if (pos >= 2 && pos <= 5)
            e = {2'b10, dec(m0), (pos == 2)};
        else if (pos >= 8)
            e = {2'b01, dec(m1), 1'b0};
        else
            e = {2'b11, 7'b1111111, 1'b0};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        got = {an, seg, frame_tick};
        check("frame", 32'(got), 32'(e));
        check("an_not_00", 32'(an == 2'b00), 32'd0);
    endtask

    initial begin
        int n;
        int len;
        int per;
        logic [3:0] r0, r1;
        reset   = 1'b0;
        rst_def = 1'b0;
        digit0  = 4'h0;
        digit1  = 4'h0;

        // reset for 3 cycles, then two frames with 3 / A
        repeat (3) step(1'b0, 4'h3, 4'hA);
        repeat (24) step(1'b1, 4'h3, 4'hA);

        // decode sweep, one value per frame
        for (int v = 0; v < 16; v++)
            repeat (12) step(1'b1, 4'(v), 4'h1);

        // tear-free: 3 for a frame, switch to 5 once inside SHOW1
        repeat (12) step(1'b1, 4'h3, 4'h7);
        while (pos != 8) step(1'b1, 4'h3, 4'h7);
        repeat (16) step(1'b1, 4'h5, 4'h7);

        // reset asserted during the second SHOW0 cycle
        while (pos != 3) step(1'b1, 4'hC, 4'h2);
        step(1'b0, 4'hC, 4'h2);
        repeat (14) step(1'b1, 4'hC, 4'h2);

        // random digits, changed at arbitrary points, over 10 frames
        for (int f = 0; f < 10; f++) begin
            r0 = 4'($urandom_range(0, 15));
            r1 = 4'($urandom_range(0, 15));
            repeat (12) step(1'b1, r0, r1);
            repeat ($urandom_range(0, 5)) step(1'b1, r1, r0);
        end

        // default-parameter instance: SHOW0 length and frame period
        rst_def = 1'b1;
        n = 0;
        while (!tick_d && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("def_first_tick", 32'(tick_d), 32'd1);
        check("def_first_delay", 32'(n), 32'd16);
        len = 0;
        while (an_d == 2'b10 && len < 30000) begin
            @(posedge clk);
            #1;
            len++;
        end
        check("def_show0_len", 32'(len), 32'd24000);
        per = len;
        while (!tick_d && per < 60000) begin
            @(posedge clk);
            #1;
            per++;
        end
        check("def_period", 32'(per), 32'd48032);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
